alu_arbiter: RTL and testbench

//   Shares one alu instance between NUM_REQ requesters (e.g. decode issue, address-gen unit).

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered ALU among NUM_REQ requesters
module alu_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*OPCODE_SIZE-1:0] req_opcode,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_b,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [WORD_SIZE-1:0]           resp_data,
  output logic                           busy,
  output logic                           alu_enable,
  output logic [OPCODE_SIZE-1:0]         alu_opcode,
  output logic [WORD_SIZE-1:0]           alu_input1,
  output logic [WORD_SIZE-1:0]           alu_input2,
  input  logic [WORD_SIZE-1:0]           alu_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;
  logic [WORD_SIZE-1:0]   in1_q, in1_d;
  logic [WORD_SIZE-1:0]   in2_q, in2_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;

  // Pick the first valid requester starting at the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and handshake outputs; ALU inputs only change on an accept so they never glitch.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    opcode_d   = opcode_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    data_d     = data_q;
    req_ready  = '0;
    resp_valid = '0;
    alu_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          opcode_d = req_opcode[win_idx*OPCODE_SIZE +: OPCODE_SIZE];
          in1_d    = req_a[win_idx*WORD_SIZE +: WORD_SIZE];
          in2_d    = req_b[win_idx*WORD_SIZE +: WORD_SIZE];
          grant_d  = win_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable = 1'b1;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        data_d  = alu_out;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) begin
          state_d = IDLE;
          rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      opcode_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      opcode_q <= opcode_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      data_q   <= data_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign alu_opcode = opcode_q;
  assign alu_input1 = in1_q;
  assign alu_input2 = in2_q;
  assign resp_data  = data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;

  localparam int NR = 2;
  localparam int WS = 16;
  localparam int OS = 5;

  localparam logic [OS-1:0] OP_ADD = 5'd0;
  localparam logic [OS-1:0] OP_AND = 5'd2;
  localparam logic [OS-1:0] OP_XOR = 5'd4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OS-1:0]  req_opcode;
  logic [NR*WS-1:0]  req_a;
  logic [NR*WS-1:0]  req_b;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [WS-1:0]     resp_data;
  logic              busy;
  logic              alu_enable;
  logic [OS-1:0]     alu_opcode;
  logic [WS-1:0]     alu_input1;
  logic [WS-1:0]     alu_input2;
  logic [WS-1:0]     alu_out;

  int total = 0;
  int bad   = 0;
  int en_count = 0;
  int en_base;

  alu_arbiter #(.NUM_REQ(NR), .WORD_SIZE(WS), .OPCODE_SIZE(OS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .alu_enable(alu_enable),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_out(alu_out)
  );

  always #5 clock = ~clock;

  // Registered ALU model: result appears the edge after alu_enable.
  always @(posedge clock) begin
    if (reset) alu_out <= '0;
    else if (alu_enable) begin
      case (alu_opcode)
        OP_ADD:  alu_out <= alu_input1 + alu_input2;
        OP_AND:  alu_out <= alu_input1 & alu_input2;
        OP_XOR:  alu_out <= alu_input1 ^ alu_input2;
        default: alu_out <= '0;
      endcase
    end
  end

  always @(posedge clock) begin
    if (alu_enable === 1'b1) en_count <= en_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: idle after reset, nothing requested
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t1_busy", busy, 0);
      chk("t1_req_ready", req_ready, 0);
      chk("t1_resp_valid", resp_valid, 0);
      chk("t1_resp_data", resp_data, 0);
      chk("t1_alu_bus", {alu_opcode, alu_input1, alu_input2}, 0);
      chk("t1_alu_enable", alu_enable, 0);
    end
    chk("t1_en_count", en_count, 0);

    // 2: single ADD from requester 0
    req_valid  = 2'b01;
    req_opcode = {OP_XOR, OP_ADD};
    req_a      = {16'h9999, 16'h0003};
    req_b      = {16'h9999, 16'h0004};
    #1;
    chk("t2_req_ready", req_ready, 2'b01);
    chk("t2_alu_en_idle", alu_enable, 0);
    @(negedge clock);
    req_valid = 2'b00;
    chk("t2_issue_en", alu_enable, 1);
    chk("t2_issue_busy", busy, 1);
    chk("t2_issue_ready", req_ready, 0);
    chk("t2_opcode", alu_opcode, OP_ADD);
    chk("t2_in1", alu_input1, 16'h0003);
    chk("t2_in2", alu_input2, 16'h0004);
    @(negedge clock);
    chk("t2_capture_en", alu_enable, 0);
    chk("t2_capture_rv", resp_valid, 0);
    chk("t2_in1_hold", alu_input1, 16'h0003);
    @(negedge clock);
    chk("t2_resp_valid", resp_valid, 2'b01);
    chk("t2_resp_data", resp_data, 16'h0007);
    resp_ready = 2'b01;
    @(negedge clock);
    resp_ready = 2'b00;
    chk("t2_done_busy", busy, 0);
    chk("t2_done_rv", resp_valid, 0);
    chk("t2_en_count", en_count, 1);

    // reset so the round-robin pointer starts again at requester 0
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // 3: both requesting XOR, grants alternate 0,1,0,1
    req_valid  = 2'b11;
    req_opcode = {OP_XOR, OP_XOR};
    req_a      = {16'h00FF, 16'h00FF};
    req_b      = {16'h0F0F, 16'h0F0F};
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_req_ready_%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clock);
      chk($sformatf("t3_issue_%0d", i), alu_enable, 1);
      @(negedge clock);
      @(negedge clock);
      chk($sformatf("t3_resp_valid_%0d", i), resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t3_resp_data_%0d", i), resp_data, 16'h0FF0);
      if (i == 3) req_valid = 2'b00;
      @(negedge clock);
    end
    resp_ready = 2'b00;
    chk("t3_busy_end", busy, 0);

    // 4: requester 1 AND, response stalled, requester 0 waits and its resp_ready is ignored
    req_valid  = 2'b10;
    req_opcode = {OP_AND, OP_ADD};
    req_a      = {16'hFFFF, 16'h0001};
    req_b      = {16'h1234, 16'h0001};
    #1;
    chk("t4_req_ready", req_ready, 2'b10);
    @(negedge clock);
    req_valid  = 2'b11;
    resp_ready = 2'b01;
    chk("t4_issue_ready", req_ready, 0);
    @(negedge clock);
    chk("t4_capture_ready", req_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk($sformatf("t4_rv_%0d", i), resp_valid, 2'b10);
      chk($sformatf("t4_data_%0d", i), resp_data, 16'h1234);
      chk($sformatf("t4_ready_%0d", i), req_ready, 0);
    end
    resp_ready = 2'b11;
    @(negedge clock);
    resp_ready = 2'b00;
    #1;
    chk("t4_idle_busy", busy, 0);
    chk("t4_req0_next", req_ready, 2'b01);

    // 5: reset while the requester-0 op sits in CAPTURE
    @(negedge clock);
    req_valid = 2'b00;
    chk("t5_issue", alu_enable, 1);
    @(negedge clock);
    chk("t5_capture_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_rv", resp_valid, 0);
    chk("t5_en", alu_enable, 0);
    chk("t5_data", resp_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("t5_no_resp_%0d", i), resp_valid, 0);
    end

    // 6: requester 0 pulses req_valid while requester 1's op is in flight
    en_base    = en_count;
    req_valid  = 2'b10;
    req_opcode = {OP_ADD, OP_ADD};
    req_a      = {16'h0010, 16'h0100};
    req_b      = {16'h0020, 16'h0200};
    #1;
    chk("t6_req_ready", req_ready, 2'b10);
    @(negedge clock);
    req_valid = 2'b00;
    @(negedge clock);
    req_valid = 2'b01;
    #1;
    chk("t6_pulse_ready", req_ready, 0);
    @(negedge clock);
    req_valid = 2'b00;
    chk("t6_rv", resp_valid, 2'b10);
    chk("t6_data", resp_data, 16'h0030);
    resp_ready = 2'b10;
    @(negedge clock);
    resp_ready = 2'b00;
    chk("t6_done_rv", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("t6_idle_%0d", i), busy, 0);
    end
    chk("t6_en_count", en_count - en_base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
